// File: rtl/exp_golomb_dec.sv
// Exp-Golomb ue(v) decoder: consumes an MSB-first byte stream one bit per cycle and emits codeNum.
// Define EXP_GOLOMB_SE_EN to map codeNum onto the signed se(v) value at the output register.
module exp_golomb_dec #(
  parameter int MAX_LZ = 15,
  parameter int OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             axiiv,
  input  logic [7:0]       axiid,
  output logic             axiir,
  output logic             axiov,
  output logic [OUT_W-1:0] axiod,
  input  logic             axior,
  output logic             err
);

  typedef enum logic {ZEROS, SUFFIX} state_t;

  state_t           state;
  logic [7:0]       bit_buf;
  logic [3:0]       bit_cnt;
  logic [4:0]       lz;
  logic [4:0]       sfx_cnt;
  logic [OUT_W-1:0] suffix;

  logic             cur_bit;
  logic             load;
  logic             take;
  logic [OUT_W-1:0] sfx_shift;
  logic [OUT_W-1:0] base_m1;
  logic [OUT_W-1:0] emit_sfx;
  logic [OUT_W-1:0] code_num;
  logic [OUT_W-1:0] out_val;

  assign cur_bit   = bit_buf[7];
  assign axiir     = (bit_cnt == 4'd0);
  assign load      = axiiv && axiir;
  // A held, unaccepted output freezes the parser so no bit is ever dropped.
  assign take      = !axiir && !(axiov && !axior);
  assign sfx_shift = (suffix << 1) | OUT_W'(cur_bit);
  assign base_m1   = OUT_W'(((OUT_W+1)'(1) << lz) - (OUT_W+1)'(1));
  assign emit_sfx  = (state == SUFFIX) ? sfx_shift : '0;
  assign code_num  = base_m1 + emit_sfx;

`ifdef EXP_GOLOMB_SE_EN
  logic [OUT_W-1:0] half_up;
  assign half_up = OUT_W'(({1'b0, code_num} + (OUT_W+1)'(1)) >> 1);
  assign out_val = code_num[0] ? half_up : ({OUT_W{1'b0}} - (code_num >> 1));
`else
  assign out_val = code_num;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ZEROS;
      bit_buf <= '0;
      bit_cnt <= '0;
      lz      <= '0;
      sfx_cnt <= '0;
      suffix  <= '0;
      axiov   <= 1'b0;
      axiod   <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (axiov && axior)
        axiov <= 1'b0;

      if (load) begin
        bit_buf <= axiid;
        bit_cnt <= 4'd8;
      end else if (take) begin
        bit_buf <= {bit_buf[6:0], 1'b0};
        bit_cnt <= bit_cnt - 4'd1;
        case (state)
          ZEROS: begin
            if (!cur_bit) begin
              // Over-long zero run: flag it and resync by dropping the run.
              if (lz == 5'(MAX_LZ)) begin
                err <= 1'b1;
                lz  <= '0;
              end else begin
                lz <= lz + 5'd1;
              end
            end else if (lz == 5'd0) begin
              axiod <= out_val;
              axiov <= 1'b1;
            end else begin
              suffix  <= '0;
              sfx_cnt <= lz;
              state   <= SUFFIX;
            end
          end
          SUFFIX: begin
            suffix  <= sfx_shift;
            sfx_cnt <= sfx_cnt - 5'd1;
            if (sfx_cnt == 5'd1) begin
              axiod <= out_val;
              axiov <= 1'b1;
              lz    <= '0;
              state <= ZEROS;
            end
          end
          default: state <= ZEROS;
        endcase
      end
    end
  end

endmodule
